// File: rtl/sbox_port_responder.sv
// rtl/sbox_port_responder.sv - AES S-box responder using x^254 inversion in GF(2^8)
// Define SBOX_INV_EN to add the per-operand inverse S-box mode and its inv port.
module sbox_port_responder #(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sbox_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] sbox_out,
  output logic       out_valid,
  input  logic       out_ready
`ifdef SBOX_INV_EN
  ,
  input  logic       inv
`endif
);

  generate
    if (UNROLL != 1 && UNROLL != 7) begin : g_bad_unroll
      $error("sbox_port_responder: UNROLL must be 1 or 7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q;
  logic [7:0] acc_q, base_q, sbox_out_q;
  logic [2:0] cnt_q;
  logic       in_ready_q, out_valid_q;
  logic [7:0] acc_d, res_d, op_d;
  logic       last_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  logic inv_q;

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  assign op_d  = inv ? inv_affine(sbox_in) : sbox_in;
  assign res_d = inv_q ? acc_d : affine(acc_d);
`else
  assign op_d  = sbox_in;
  assign res_d = affine(acc_d);
`endif

  // Exponent 254 = 0b11111110 MSB first: six square-multiply steps, then a lone square.
  always_comb begin
    acc_d  = acc_q;
    last_d = 1'b0;
    if (UNROLL == 7) begin
      for (int n = 0; n < 7; n++) begin
        acc_d = gf_mul(acc_d, acc_d);
        if (n < 6) acc_d = gf_mul(acc_d, base_q);
      end
      last_d = 1'b1;
    end else begin
      acc_d = gf_mul(acc_q, acc_q);
      if (cnt_q != 3'd6) acc_d = gf_mul(acc_d, base_q);
      last_d = (cnt_q == 3'd6);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 8'h00;
      base_q      <= 8'h00;
      cnt_q       <= 3'd0;
      sbox_out_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SBOX_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= op_d;
            base_q     <= op_d;
            cnt_q      <= 3'd0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
`ifdef SBOX_INV_EN
            inv_q      <= inv;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (last_d) begin
            sbox_out_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sbox_out  = sbox_out_q;

endmodule
